// File: rtl/decode_stage_if.sv
// Fetch-to-decode, register-file read and ID/EX register signals of the decode stage.
// master = surrounding pipeline, slave = decode_stage.
interface decode_stage_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   if_valid;
  logic [31:0]            if_instr;
  logic [31:0]            if_pc;
  logic                   flush;
  logic                   stall_out;
  logic [4:0]             rf_read_reg1;
  logic [4:0]             rf_read_reg2;
  logic [31:0]            rf_read_data1;
  logic [31:0]            rf_read_data2;
  logic                   ex_valid;
  logic [31:0]            ex_pc;
  logic [31:0]            ex_rs_data;
  logic [31:0]            ex_rt_data;
  logic [31:0]            ex_imm;
  logic [4:0]             ex_dest;
  logic                   ex_reg_write;
  logic                   ex_mem_read;
  logic                   ex_mem_write;
  logic                   ex_alu_src;
  logic [2:0]             ex_alu_op;
  logic                   ex_illegal;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output if_valid, if_instr, if_pc, flush, rf_read_data1, rf_read_data2,
    input  stall_out, rf_read_reg1, rf_read_reg2,
    input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_dest,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op,
    input  ex_illegal, stall_count
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, rf_read_data1, rf_read_data2,
    output stall_out, rf_read_reg1, rf_read_reg2,
    output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_dest,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op,
    output ex_illegal, stall_count
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset decode stage: 1-cycle decode into ID/EX registers, load-use stall
// detection against the instruction in EX, flush, and a saturating stall counter.
module decode_stage #(
  parameter int STALL_CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;

  assign opcode = bus.if_instr[31:26];
  assign rs     = bus.if_instr[25:21];
  assign rt     = bus.if_instr[20:16];
  assign rd     = bus.if_instr[15:11];
  assign funct  = bus.if_instr[5:0];

  assign bus.rf_read_reg1 = rs;
  assign bus.rf_read_reg2 = rt;

  logic       d_legal;
  logic [2:0] d_alu_op;
  logic [4:0] d_dest;
  logic       d_reg_write;
  logic       d_mem_read;
  logic       d_mem_write;
  logic       d_alu_src;

  always_comb begin
    d_legal     = 1'b1;
    d_alu_op    = 3'd0;
    d_dest      = 5'd0;
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_alu_src   = 1'b0;
    case (opcode)
      6'h00: begin
        d_dest      = rd;
        d_reg_write = 1'b1;
        case (funct)
          6'h20:   d_alu_op = 3'd0;
          6'h22:   d_alu_op = 3'd1;
          6'h24:   d_alu_op = 3'd2;
          6'h25:   d_alu_op = 3'd3;
          6'h2A:   d_alu_op = 3'd4;
          default: d_legal  = 1'b0;
        endcase
      end
      6'h08: begin
        d_dest      = rt;
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
      end
      6'h23: begin
        d_dest      = rt;
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_mem_read  = 1'b1;
      end
      6'h2B: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
    // r0 is hardwired; never let a write to it reach writeback.
    if (d_dest == 5'd0) d_reg_write = 1'b0;
  end

  // Load-use hazard: rt only matters for instructions that actually read it.
  logic uses_rt;
  logic hazard;
  logic stall;

  assign uses_rt = (opcode == 6'h00) || (opcode == 6'h2B);
  assign hazard  = bus.ex_valid && bus.ex_mem_read && (bus.ex_dest != 5'd0) &&
                   ((bus.ex_dest == rs) || ((bus.ex_dest == rt) && uses_rt));
  assign stall   = hazard && !bus.flush;
  assign bus.stall_out = stall;

  logic load;
  logic illegal_now;

  assign load        = bus.if_valid && d_legal && !stall && !bus.flush;
  assign illegal_now = bus.if_valid && !d_legal && !stall && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_illegal   <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_alu_src   <= 1'b0;
      bus.ex_alu_op    <= 3'd0;
      bus.ex_dest      <= 5'd0;
      bus.ex_pc        <= 32'd0;
      bus.ex_imm       <= 32'd0;
      bus.ex_rs_data   <= 32'd0;
      bus.ex_rt_data   <= 32'd0;
      bus.stall_count  <= '0;
    end else begin
      // Data fields are don't-care in a bubble, so they load unconditionally.
      bus.ex_pc        <= bus.if_pc;
      bus.ex_imm       <= {{16{bus.if_instr[15]}}, bus.if_instr[15:0]};
      bus.ex_rs_data   <= bus.rf_read_data1;
      bus.ex_rt_data   <= bus.rf_read_data2;
      bus.ex_valid     <= load;
      bus.ex_illegal   <= illegal_now;
      bus.ex_reg_write <= load ? d_reg_write : 1'b0;
      bus.ex_mem_read  <= load ? d_mem_read  : 1'b0;
      bus.ex_mem_write <= load ? d_mem_write : 1'b0;
      bus.ex_alu_src   <= load ? d_alu_src   : 1'b0;
      bus.ex_alu_op    <= load ? d_alu_op    : 3'd0;
      bus.ex_dest      <= load ? d_dest      : 5'd0;
      if (stall && (bus.stall_count != {STALL_CNT_W{1'b1}}))
        bus.stall_count <= bus.stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.STALL_CNT_W(CW)) bus ();

  decode_stage #(.STALL_CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [31:0] ADD_R3  = 32'h0022_1820;
  localparam logic [31:0] SUB_R7  = 32'h0064_3822;
  localparam logic [31:0] SLT_R8  = 32'h0022_402A;
  localparam logic [31:0] SW_R2   = 32'hAC22_0008;
  localparam logic [31:0] LW_R4   = 32'h8C24_FFFC;
  localparam logic [31:0] ADD_R5  = 32'h0082_2820;
  localparam logic [31:0] LW_R0   = 32'h8C20_0000;
  localparam logic [31:0] ADD_R6  = 32'h0000_3020;
  localparam logic [31:0] ILL_OP  = 32'hFC00_0000;
  localparam logic [31:0] ILL_FN  = 32'h0022_1821;
  localparam logic [31:0] ADDI_R1 = 32'h2001_8000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc,
                       input logic fl, input logic [31:0] d1, input logic [31:0] d2);
    bus.if_valid      = vld;
    bus.if_instr      = instr;
    bus.if_pc         = pc;
    bus.flush         = fl;
    bus.rf_read_data1 = d1;
    bus.rf_read_data2 = d2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    repeat (2) step();
    check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_stall_count", {29'd0, bus.stall_count}, 32'd0);
    check("rst_stall_out", {31'd0, bus.stall_out}, 32'd0);
    rst_n = 1'b1;

    // add r3,r1,r2 decodes on the very first edge after reset release
    drive(1'b1, ADD_R3, 32'h100, 1'b0, 32'd5, 32'd7);
    #1;
    check("rf_reg1", {27'd0, bus.rf_read_reg1}, 32'd1);
    check("rf_reg2", {27'd0, bus.rf_read_reg2}, 32'd2);
    step();
    check("add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("add_op", {29'd0, bus.ex_alu_op}, 32'd0);
    check("add_dest", {27'd0, bus.ex_dest}, 32'd3);
    check("add_rs", bus.ex_rs_data, 32'd5);
    check("add_rt", bus.ex_rt_data, 32'd7);
    check("add_rw", {31'd0, bus.ex_reg_write}, 32'd1);
    check("add_src", {31'd0, bus.ex_alu_src}, 32'd0);
    check("add_pc", bus.ex_pc, 32'h100);

    drive(1'b1, SUB_R7, 32'h104, 1'b0, 32'd1, 32'd2);
    step();
    check("sub_op", {29'd0, bus.ex_alu_op}, 32'd1);
    check("sub_dest", {27'd0, bus.ex_dest}, 32'd7);

    drive(1'b1, SLT_R8, 32'h108, 1'b0, 32'd1, 32'd2);
    step();
    check("slt_op", {29'd0, bus.ex_alu_op}, 32'd4);
    check("slt_dest", {27'd0, bus.ex_dest}, 32'd8);

    drive(1'b1, SW_R2, 32'h10C, 1'b0, 32'd1, 32'd2);
    step();
    check("sw_mw", {31'd0, bus.ex_mem_write}, 32'd1);
    check("sw_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    check("sw_dest", {27'd0, bus.ex_dest}, 32'd0);
    check("sw_src", {31'd0, bus.ex_alu_src}, 32'd1);
    check("sw_imm", bus.ex_imm, 32'd8);

    // load-use: lw r4 then add r5,r4,r2
    drive(1'b1, LW_R4, 32'h110, 1'b0, 32'd0, 32'd0);
    step();
    check("lw_mr", {31'd0, bus.ex_mem_read}, 32'd1);
    check("lw_imm", bus.ex_imm, 32'hFFFF_FFFC);
    drive(1'b1, ADD_R5, 32'h114, 1'b0, 32'd0, 32'd0);
    #1;
    check("lu_stall", {31'd0, bus.stall_out}, 32'd1);
    step();
    check("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
    check("lu_stall_drop", {31'd0, bus.stall_out}, 32'd0);
    check("lu_count", {29'd0, bus.stall_count}, 32'd1);
    step();
    check("lu_issue", {31'd0, bus.ex_valid}, 32'd1);
    check("lu_issue_dest", {27'd0, bus.ex_dest}, 32'd5);
    check("lu_count_hold", {29'd0, bus.stall_count}, 32'd1);

    // lw r0 followed by a reader of r0: no hazard, no write
    drive(1'b1, LW_R0, 32'h118, 1'b0, 32'd0, 32'd0);
    step();
    check("lw0_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    check("lw0_mr", {31'd0, bus.ex_mem_read}, 32'd1);
    drive(1'b1, ADD_R6, 32'h11C, 1'b0, 32'd0, 32'd0);
    #1;
    check("lw0_nostall", {31'd0, bus.stall_out}, 32'd0);
    step();
    check("lw0_use_valid", {31'd0, bus.ex_valid}, 32'd1);

    // flush during a load-use stall
    drive(1'b1, LW_R4, 32'h120, 1'b0, 32'd0, 32'd0);
    step();
    drive(1'b1, ADD_R5, 32'h124, 1'b1, 32'd0, 32'd0);
    #1;
    check("fl_stall_out", {31'd0, bus.stall_out}, 32'd0);
    step();
    check("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("fl_illegal", {31'd0, bus.ex_illegal}, 32'd0);
    check("fl_count", {29'd0, bus.stall_count}, 32'd1);

    // illegal opcode, illegal funct, then addi with negative immediate
    drive(1'b1, ILL_OP, 32'h128, 1'b0, 32'd0, 32'd0);
    step();
    check("ill_op_flag", {31'd0, bus.ex_illegal}, 32'd1);
    check("ill_op_valid", {31'd0, bus.ex_valid}, 32'd0);
    drive(1'b1, ILL_FN, 32'h12C, 1'b0, 32'd0, 32'd0);
    step();
    check("ill_fn_flag", {31'd0, bus.ex_illegal}, 32'd1);
    check("ill_fn_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    drive(1'b1, ADDI_R1, 32'h130, 1'b0, 32'd0, 32'd0);
    step();
    check("addi_illegal", {31'd0, bus.ex_illegal}, 32'd0);
    check("addi_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("addi_imm", bus.ex_imm, 32'hFFFF_8000);
    check("addi_dest", {27'd0, bus.ex_dest}, 32'd1);
    check("addi_src", {31'd0, bus.ex_alu_src}, 32'd1);

    // no valid instruction -> bubble
    drive(1'b0, ADD_R3, 32'h134, 1'b0, 32'd0, 32'd0);
    step();
    check("inv_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("inv_rw", {31'd0, bus.ex_reg_write}, 32'd0);

    // repeated load-use pairs drive the 3-bit counter into saturation
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, LW_R4, 32'h200, 1'b0, 32'd0, 32'd0);
      step();
      drive(1'b1, ADD_R5, 32'h204, 1'b0, 32'd0, 32'd0);
      step();
      step();
    end
    check("sat_count", {29'd0, bus.stall_count}, 32'd7);

    // asynchronous reset in the middle of a stall
    drive(1'b1, LW_R4, 32'h300, 1'b0, 32'd0, 32'd0);
    step();
    drive(1'b1, ADD_R5, 32'h304, 1'b0, 32'd0, 32'd0);
    #1;
    check("ar_pre_stall", {31'd0, bus.stall_out}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_stall_out", {31'd0, bus.stall_out}, 32'd0);
    check("ar_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("ar_mr", {31'd0, bus.ex_mem_read}, 32'd0);
    check("ar_dest", {27'd0, bus.ex_dest}, 32'd0);
    check("ar_pc", bus.ex_pc, 32'd0);
    check("ar_imm", bus.ex_imm, 32'd0);
    check("ar_count", {29'd0, bus.stall_count}, 32'd0);
    step();
    check("ar_held_valid", {31'd0, bus.ex_valid}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    step();
    check("ar_after_valid", {31'd0, bus.ex_valid}, 32'd0);
    drive(1'b1, ADD_R3, 32'h400, 1'b0, 32'd9, 32'd4);
    step();
    check("ar_resume_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("ar_resume_rs", bus.ex_rs_data, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of test, expected finish before 20000");
    $fatal(1);
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the stall performance counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_valid  input  1  fetch presents a valid instruction.
REQ-005 SHALL have port if_instr  input  32  instruction word from fetch.
REQ-006 SHALL have port if_pc  input  32  PC of if_instr.
REQ-007 SHALL have port flush  input  1  discard the current decode slot.
REQ-008 SHALL have port stall_out  output  1  tells fetch to hold if_instr and if_pc.
REQ-009 SHALL have ports rf_read_reg1 and rf_read_reg2  output  5 each  register-file read addresses.
REQ-010 SHALL have ports rf_read_data1 and rf_read_data2  input  32 each  register-file read data.
REQ-011 SHALL have registered ID/EX outputs: ex_valid 1, ex_pc 32, ex_rs_data 32, ex_rt_data 32, ex_imm 32, ex_dest 5, ex_reg_write 1, ex_mem_read 1, ex_mem_write 1, ex_alu_src 1, ex_alu_op 3, ex_illegal 1.
REQ-012 SHALL have port stall_count  output  STALL_CNT_W  saturating count of stall cycles.

Function
REQ-013 SHALL drive rf_read_reg1 = if_instr[25:21] and rf_read_reg2 = if_instr[20:16] combinationally.
REQ-014 SHALL capture rf_read_data1/2 and all decoded fields into the ex_* registers on the rising edge, giving 1-cycle decode latency.
REQ-015 SHALL decode R-type (opcode 0x00) functs add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A to ex_alu_op 0, 1, 2, 3, 4 respectively, with ex_dest = rd, ex_reg_write = 1, ex_alu_src = 0.
REQ-016 SHALL decode addi 0x08 as alu_op 0, alu_src 1, dest rt, reg_write 1.
REQ-017 SHALL decode lw 0x23 as alu_op 0, alu_src 1, dest rt, reg_write 1, mem_read 1.
REQ-018 SHALL decode sw 0x2B as alu_op 0, alu_src 1, mem_write 1, reg_write 0, dest 0.
REQ-019 SHALL set ex_imm to the sign extension of if_instr[15:0] for every instruction.
REQ-020 SHALL force ex_reg_write to 0 whenever the decoded dest is register 0.
REQ-021 SHALL treat any other opcode or funct as illegal: load a bubble and pulse ex_illegal high for that one cycle with ex_valid = 0.
REQ-022 SHALL load a bubble when if_valid = 0: ex_valid = 0 and all control outputs 0; data outputs are don't-care.
REQ-023 SHALL assert stall_out combinationally when ex_valid & ex_mem_read & ex_dest != 0 and either of these holds: ex_dest == rs, or ex_dest == rt and the instruction is R-type or sw.
REQ-024 SHALL, while stall_out = 1, load a bubble into ex_*; fetch holds its outputs, so the same instruction re-decodes next cycle with stall_out = 0.
REQ-025 SHALL give flush priority over stall and over a valid instruction: next ex_valid = 0 and ex_illegal = 0, and stall_out is forced 0.
REQ-026 SHALL increment stall_count by 1 on each rising edge where stall_out = 1 and flush = 0, saturating at all-ones.
REQ-027 SHALL rely on the register file's negedge write for same-cycle write-then-read; this stage performs no writeback bypass.

Reset
REQ-028 SHALL, on rst_n = 0 and regardless of clk, set ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write and ex_alu_src to 0, set ex_alu_op, ex_dest, ex_pc, ex_imm, ex_rs_data, ex_rt_data and stall_count to 0, and thereby set stall_out to 0.
REQ-029 SHALL begin normal decode on the first rising edge after rst_n deasserts, with no bubble required.
REQ-030 SHALL, when reset is asserted mid-stall, drop the stall immediately and ensure that no held instruction reaches ex_valid.

Verification
REQ-031 SHALL pass this scenario: add r3,r1,r2 (0x00221820) with rf data 5 and 7 -> next cycle ex_valid=1, ex_alu_op=0, ex_dest=3, ex_rs_data=5, ex_rt_data=7, ex_reg_write=1.
REQ-032 SHALL pass this scenario: lw r4,-4(r1) followed by add r5,r4,r2 -> stall_out=1 for exactly one cycle, one bubble, then add issues; stall_count=1.
REQ-033 SHALL pass this scenario: lw r0 followed by a consumer of r0 -> no stall; ex_reg_write=0 for the lw.
REQ-034 SHALL pass this scenario: flush asserted during a load-use stall -> stall_out=0, next ex_valid=0, stall_count unchanged.
REQ-035 SHALL pass this scenario: opcode 0x3F -> ex_illegal=1 for one cycle with ex_valid=0; addi r1,r0,0x8000 -> ex_imm=0xFFFF8000.
REQ-036 SHALL pass this scenario: rst_n pulsed low asynchronously mid-stream -> all ex_* outputs and stall_count read 0 before the next clock edge.
